// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the BCD display sampler
package disp_pkg;
  localparam int BCD_W = 12;
  localparam int BIN_W = 8;
  localparam int NUM_CH = 3;
  localparam int CONV_STEPS = 8;
  localparam int DD_W = BCD_W + BIN_W;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  function automatic logic [BIN_W-1:0] magnitude(logic [BIN_W-1:0] x);
    return x[BIN_W-1] ? -x : x;
  endfunction
endpackage

// File: rtl/bcd_dd_step.sv
// bcd_dd_step: one combinational double-dabble step (add-3 then shift left)
module bcd_dd_step
  import disp_pkg::*;
(
  input  logic [DD_W-1:0] a,
  output logic [DD_W-1:0] y
);
  logic [DD_W-1:0] adj;
  assign adj[BIN_W-1:0] = a[BIN_W-1:0];
  for (genvar n = 0; n < BCD_W / 4; n++) begin : g_nib
    logic [3:0] d;
    assign d = a[BIN_W+4*n +: 4];
    assign adj[BIN_W+4*n +: 4] = d >= 4'd5 ? d + 4'd3 : d;
  end
  assign y = adj << 1;
endmodule

// File: rtl/disp_bcd_sampler.sv
// disp_bcd_sampler: periodic 3-channel binary-to-BCD sampler with atomic output update.
// Define DISP_SIGNED_EN to treat inputs as two's complement (magnitude + neg flags).
module disp_bcd_sampler
  import disp_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BIN_W-1:0]  v0_in,
  input  logic [BIN_W-1:0]  v1_in,
  input  logic [BIN_W-1:0]  s4_in,
  output logic [BCD_W-1:0]  v0_bcd,
  output logic [BCD_W-1:0]  v1_bcd,
  output logic [BCD_W-1:0]  s4_bcd,
  output logic [NUM_CH-1:0] neg,
  output logic              valid,
  output logic              busy
);
  state_t state, nxt;
  logic [23:0] cnt;
  logic [2:0] step;
  logic [1:0] ch;
  logic [NUM_CH-1:0][BIN_W-1:0] op, cap;
  logic [BCD_W-1:0] res0, res1;
  logic [DD_W-1:0] w, dd_in, dd_out;
  logic tick, last, fin;
  assign tick = cnt == 24'(REFRESH_CYCLES - 1);
  assign last = step == 3'(CONV_STEPS - 1);
  assign fin = state == CONV && last && ch == 2'(NUM_CH - 1);
  assign valid = state == LOAD;
  assign busy = state != IDLE;
  // operand is injected on the first step of each channel, so no separate load cycle is needed
  assign dd_in = step == 3'd0 ? {{BCD_W{1'b0}}, op[ch]} : w;
  bcd_dd_step u_step (.a(dd_in), .y(dd_out));
`ifdef DISP_SIGNED_EN
  logic [NUM_CH-1:0] sgn, neg_r;
  assign cap = {magnitude(s4_in), magnitude(v1_in), magnitude(v0_in)};
  assign neg = neg_r;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sgn <= '0;
      neg_r <= '0;
    end else begin
      if (state == IDLE && tick) sgn <= {s4_in[BIN_W-1], v1_in[BIN_W-1], v0_in[BIN_W-1]};
      if (fin) neg_r <= sgn;
    end
  end
`else
  assign cap = {s4_in, v1_in, v0_in};
  assign neg = '0;
`endif
  always_ff @(posedge Clk) state <= Rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE && tick) ? CONV : fin ? LOAD : (state == LOAD) ? IDLE : state;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      step <= '0;
      ch <= '0;
      op <= '0;
      w <= '0;
      res0 <= '0;
      res1 <= '0;
      v0_bcd <= '0;
      v1_bcd <= '0;
      s4_bcd <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 24'd1;
      if (state == IDLE && tick) begin
        op <= cap;
        step <= '0;
        ch <= '0;
      end
      if (state == CONV) begin
        w <= dd_out;
        step <= step + 3'd1;
        if (last) ch <= ch + 2'd1;
        if (last && ch == 2'd0) res0 <= dd_out[DD_W-1:BIN_W];
        if (last && ch == 2'd1) res1 <= dd_out[DD_W-1:BIN_W];
      end
      // outputs are written on the edge entering LOAD so they are new while valid is high
      if (fin) begin
        v0_bcd <= res0;
        v1_bcd <= res1;
        s4_bcd <= dd_out[DD_W-1:BIN_W];
      end
    end
  end
endmodule

// File: tb/tb_disp_bcd_sampler.sv
// tb_disp_bcd_sampler: randomized self-checking bench with a cycle-level reference model
module tb_disp_bcd_sampler;
  localparam int R = 32;
  logic Clk = 0;
  logic Rst = 1;
  logic [7:0] v0_in = 0, v1_in = 0, s4_in = 0;
  logic [11:0] v0_bcd, v1_bcd, s4_bcd;
  logic [2:0] neg;
  logic valid, busy;
  int checks = 0, failures = 0, k = 0, sweep_i = 0;
  bit sweep_on = 0;
  logic [11:0] exp_bcd [3];
  logic [11:0] pend [3];
  logic [2:0] exp_neg, pend_neg;
  logic [23:0] dq [$];

  disp_bcd_sampler #(.REFRESH_CYCLES(R)) dut (
    .Clk(Clk), .Rst(Rst), .v0_in(v0_in), .v1_in(v1_in), .s4_in(s4_in),
    .v0_bcd(v0_bcd), .v1_bcd(v1_bcd), .s4_bcd(s4_bcd),
    .neg(neg), .valid(valid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(int x);
    return 12'((x / 100) * 256 + ((x / 10) % 10) * 16 + x % 10);
  endfunction

  function automatic int mag(int x);
`ifdef DISP_SIGNED_EN
    return x >= 128 ? 256 - x : x;
`else
    return x;
`endif
  endfunction

  function automatic logic sgn(int x);
`ifdef DISP_SIGNED_EN
    return x >= 128;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(logic vexp, logic bexp);
    check("valid", valid, vexp);
    check("busy", busy, bexp);
    check("v0_bcd", v0_bcd, exp_bcd[0]);
    check("v1_bcd", v1_bcd, exp_bcd[1]);
    check("s4_bcd", s4_bcd, exp_bcd[2]);
    check("neg", neg, exp_neg);
  endtask

  task automatic pick_inputs(logic cap);
    if (cap && dq.size() > 0) {s4_in, v1_in, v0_in} = dq.pop_front();
    else if (cap && sweep_on && sweep_i < 256) begin
      v0_in = 8'(sweep_i);
      v1_in = 8'(255 - sweep_i);
      s4_in = 8'((sweep_i * 7) % 256);
      sweep_i++;
    end else begin
      v0_in = 8'($urandom);
      v1_in = 8'($urandom);
      s4_in = 8'($urandom);
    end
    if (cap) begin
      pend[0] = to_bcd(mag(int'(v0_in)));
      pend[1] = to_bcd(mag(int'(v1_in)));
      pend[2] = to_bcd(mag(int'(s4_in)));
      pend_neg = {sgn(int'(s4_in)), sgn(int'(v1_in)), sgn(int'(v0_in))};
    end
  endtask

  task automatic step_cycle();
    int p;
    logic cap, vexp, bexp;
    @(negedge Clk);
    p = k >= R - 1 ? (k - (R - 1)) % R : -1;
    cap = p == 0;
    vexp = k >= R && p == 25;
    bexp = k >= R && p >= 1 && p <= 25;
    if (vexp) begin
      exp_bcd = pend;
      exp_neg = pend_neg;
    end
    check_outputs(vexp, bexp);
    pick_inputs(cap);
    k++;
  endtask

  task automatic do_reset();
    Rst = 1;
    @(negedge Clk);
    exp_bcd = '{default: 12'h000};
    exp_neg = 3'b000;
    check_outputs(1'b0, 1'b0);
    Rst = 0;
    k = 0;
    pick_inputs(1'b0);
    k = 1;
  endtask

  initial begin
    dq.push_back({8'd10, 8'd9, 8'd0});
    dq.push_back({8'd199, 8'd100, 8'd255});
    dq.push_back({8'($urandom), 8'($urandom), 8'd12});
    dq.push_back({8'($urandom), 8'($urandom), 8'd34});
    dq.push_back({8'h7F, 8'hFF, 8'h80});
    repeat (2) @(negedge Clk);
    do_reset();
    repeat (8 * R) step_cycle();
    do step_cycle(); while (!(k - 1 >= R && ((k - 1 - (R - 1)) % R) == 10));
    do_reset();
    repeat (3 * R) step_cycle();
    sweep_on = 1;
    repeat (257 * R + 30) step_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
